// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, then a sign fix-up.
// Produces a 2*size-bit signed or unsigned product size+1 cycles after acceptance.
module seq_multiplier #(
  parameter int unsigned size = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic [size-1:0]     src1_i,
  input  logic [size-1:0]     src2_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [2*size-1:0]   product_o
);

  localparam int unsigned SW = size;
  localparam int unsigned PW = 2 * size;
  localparam int unsigned IW = $clog2(size);
  localparam int unsigned CW = IW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   mcand_q, mcand_d;
  logic [SW-1:0]   mplier_q, mplier_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d  = CALC;
          // Magnitudes: -2^(size-1) negates to itself, which reads correctly as unsigned.
          mcand_d  = (signed_i && src1_i[SW-1]) ? (~src1_i + SW'(1)) : src1_i;
          mplier_d = (signed_i && src2_i[SW-1]) ? (~src2_i + SW'(1)) : src2_i;
          neg_d    = signed_i & (src1_i[SW-1] ^ src2_i[SW-1]);
          acc_d    = '0;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (mplier_q[cnt_q[IW-1:0]]) begin
          acc_d = acc_q + (PW'(mcand_q) << cnt_q);
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(size - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        product_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
        state_d   = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q == CALC) || (state_q == FIX);
  assign done_o    = (state_q == DONE);
  assign product_o = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (size = 32) with hand-computed products.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks   = 0;
  int failures = 0;

  seq_multiplier #(.size(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst_n),
    .start_i   (start),
    .signed_i  (sgn),
    .src1_i    (src1),
    .src2_i    (src2),
    .busy_o    (busy),
    .done_o    (done),
    .product_o (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
    end
  endtask

  // Present a request for one edge; returns at the negedge just after acceptance.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    start = 1'b1;
    src1  = a;
    src2  = b;
    sgn   = s;
    @(negedge clk);
    start = 1'b0;
    src1  = 32'hDEAD_BEEF;
    src2  = 32'hDEAD_BEEF;
  endtask

  // Wait for done; n = cycles after the acceptance sample, nbusy = busy samples seen.
  task automatic wait_done(input bit inject, output int n, output int nbusy);
    n     = 0;
    nbusy = 0;
    while (!done && n < 200) begin
      if (busy) nbusy++;
      if (inject && (n == 5 || n == 32)) begin
        start = 1'b1; src1 = 32'd9; src2 = 32'd9; sgn = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 64'(n), 64'd33);
  endtask

  // Count done pulses over a window of cycles.
  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int n;
    int nb;
    int pulses;

    rst_n = 1'b0;
    start = 1'b1;
    sgn   = 1'b0;
    src1  = 32'd7;
    src2  = 32'd6;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned basic: latency, busy width, single-cycle done
    start_op(32'd7, 32'd6, 1'b0);
    check("basic_no_early", product, 64'd0);
    wait_done(1'b0, n, nb);
    check("basic_latency", 64'(n), 64'd33);
    check("basic_busy_cycles", 64'(nb), 64'd33);
    check("basic_product", product, 64'd42);
    @(negedge clk);
    check("basic_done_pulse", 64'(done), 64'd0);
    check("basic_hold", product, 64'd42);

    start_op(32'hFFFF_FFFD, 32'd5, 1'b1);
    wait_done(1'b0, n, nb);
    check("neg3x5", product, 64'hFFFF_FFFF_FFFF_FFF1);

    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(1'b0, n, nb);
    check("min_min_signed", product, 64'h4000_0000_0000_0000);

    start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done(1'b0, n, nb);
    check("min_min_unsigned", product, 64'h4000_0000_0000_0000);

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(1'b0, n, nb);
    check("max_max_unsigned", product, 64'hFFFF_FFFE_0000_0001);

    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(1'b0, n, nb);
    check("neg1_neg1_signed", product, 64'd1);

    start_op(32'd0, 32'hFFFF_FFFF, 1'b0);
    wait_done(1'b0, n, nb);
    check("zero_latency", 64'(n), 64'd33);
    check("zero_product", product, 64'd0);

    // start during CALC and FIX is ignored
    start_op(32'd7, 32'd6, 1'b0);
    wait_done(1'b1, n, nb);
    check("ign_latency", 64'(n), 64'd33);
    check("ign_product", product, 64'd42);
    count_done(40, pulses);
    check("ign_extra_done", 64'(pulses), 64'd0);
    check("ign_idle", 64'(busy), 64'd0);

    // Back-to-back: second request issued in the DONE cycle
    start_op(32'd2, 32'd3, 1'b0);
    wait_done(1'b0, n, nb);
    check("b2b_first", product, 64'd6);
    start_op(32'd4, 32'd5, 1'b0);
    check("b2b_busy", 64'(busy), 64'd1);
    check("b2b_hold", product, 64'd6);
    wait_done(1'b0, n, nb);
    check("b2b_gap", 64'(n + 1), 64'd34);
    check("b2b_second", product, 64'd20);

    // Reset in the middle of 100x100 after a 42 result
    start_op(32'd7, 32'd6, 1'b0);
    wait_done(1'b0, n, nb);
    check("mid_pre", product, 64'd42);
    @(negedge clk);
    start_op(32'd100, 32'd100, 1'b0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_done", 64'(done), 64'd0);
    check("mid_product", product, 64'd0);
    count_done(60, pulses);
    check("mid_no_done", 64'(pulses), 64'd0);
    check("mid_product_after", product, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
